// File: rtl/logic_gates_checker_if.sv
// Bundle between a logic_gates sweep driver (master) and the checker (slave).
interface logic_gates_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             clear;
  logic             sample_valid;
  logic             a;
  logic             b;
  logic             and_gate;
  logic             or_gate;
  logic             not_gate;
  logic             nand_gate;
  logic             nor_gate;
  logic             xor_gate;
  logic             xnor_gate;
  logic [6:0]       err_flags;
  logic [CNT_W-1:0] mismatch_count;
  logic [CNT_W-1:0] sample_count;
  logic [3:0]       coverage;
  logic             done;
  logic             pass;

  modport master (
    output clear, sample_valid, a, b,
    output and_gate, or_gate, not_gate, nand_gate, nor_gate, xor_gate, xnor_gate,
    input  err_flags, mismatch_count, sample_count, coverage, done, pass
  );

  modport slave (
    input  clear, sample_valid, a, b,
    input  and_gate, or_gate, not_gate, nand_gate, nor_gate, xor_gate, xnor_gate,
    output err_flags, mismatch_count, sample_count, coverage, done, pass
  );
endinterface

// File: rtl/logic_gates_checker.sv
// Two-stage checker for the logic_gates block: capture a sample, then compare it against
// the golden truth table and accumulate sticky flags, saturating counters and coverage.
module logic_gates_checker #(
  parameter int unsigned CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  logic_gates_checker_if.slave bus
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StRun      = 2'd1;
  localparam logic [1:0] StComplete = 2'd2;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Stage 1 capture registers
  logic       s1_valid_q;
  logic       s1_a_q;
  logic       s1_b_q;
  logic [6:0] s1_gates_q;

  // Stage 2 result registers
  logic [6:0]       err_q, err_d;
  logic [CNT_W-1:0] mism_cnt_q, mism_cnt_d;
  logic [CNT_W-1:0] samp_cnt_q, samp_cnt_d;
  logic [3:0]       cov_q, cov_d;
  logic [1:0]       state_q, state_d;

  logic [6:0] golden;
  logic [6:0] mism;

  // Capture the sample; clear drops both the new and the in-flight sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= 1'b0;
      s1_b_q     <= 1'b0;
      s1_gates_q <= 7'd0;
    end else begin
      s1_valid_q <= bus.sample_valid & ~bus.clear;
      s1_a_q     <= bus.a;
      s1_b_q     <= bus.b;
      s1_gates_q <= {bus.xnor_gate, bus.xor_gate, bus.nor_gate, bus.nand_gate,
                     bus.not_gate, bus.or_gate, bus.and_gate};
    end
  end

  // Golden truth table in err_flags bit order and the resulting mismatch vector.
  always_comb begin
    golden = {~(s1_a_q ^ s1_b_q), s1_a_q ^ s1_b_q, ~(s1_a_q | s1_b_q),
              ~(s1_a_q & s1_b_q), ~s1_a_q, s1_a_q | s1_b_q, s1_a_q & s1_b_q};
    mism   = golden ^ s1_gates_q;
  end

  // Next-state for the check stage, counters and FSM; clear overrides everything.
  always_comb begin
    err_d      = err_q;
    mism_cnt_d = mism_cnt_q;
    samp_cnt_d = samp_cnt_q;
    cov_d      = cov_q;
    state_d    = state_q;
    if (s1_valid_q) begin
      err_d = err_q | mism;
      if ((|mism) && (mism_cnt_q != CntMax)) begin
        mism_cnt_d = mism_cnt_q + CntOne;
      end
      if (samp_cnt_q != CntMax) begin
        samp_cnt_d = samp_cnt_q + CntOne;
      end
      cov_d[{s1_a_q, s1_b_q}] = 1'b1;
      if (state_q != StComplete) begin
        state_d = (cov_d == 4'hF) ? StComplete : StRun;
      end
    end
    if (bus.clear) begin
      err_d      = 7'd0;
      mism_cnt_d = '0;
      samp_cnt_d = '0;
      cov_d      = 4'd0;
      state_d    = StIdle;
    end
  end

  // Result and FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q      <= 7'd0;
      mism_cnt_q <= '0;
      samp_cnt_q <= '0;
      cov_q      <= 4'd0;
      state_q    <= StIdle;
    end else begin
      err_q      <= err_d;
      mism_cnt_q <= mism_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      cov_q      <= cov_d;
      state_q    <= state_d;
    end
  end

  assign bus.err_flags      = err_q;
  assign bus.mismatch_count = mism_cnt_q;
  assign bus.sample_count   = samp_cnt_q;
  assign bus.coverage       = cov_q;
  assign bus.done           = (state_q == StComplete);
  assign bus.pass           = (state_q == StComplete) & ~(|err_q);

endmodule
